// File: rtl/stream_arb_pkg.sv
// Shared types and default sizing for the round-robin stream arbiter.
// Holds the packet-lock FSM state type used when STREAM_RR_ARB_PKT_LOCK_EN is defined.
package stream_arb_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_N     = 4;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } lock_state_e;

endpackage

// File: rtl/stream_rr_arb_rr_pick.sv
// Round-robin priority search: first set request after ptr, wrapping modulo N.
// Purely combinational; the caller owns the pointer register.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          any,
  output logic [IW-1:0] idx
);

  always_comb begin : search
    int   c;
    logic found;
    any   = |req;
    idx   = '0;
    found = 1'b0;
    c     = 0;
    // Scan ptr+1 .. ptr+N so the previous winner is considered last.
    for (int i = 1; i <= N; i++) begin
      c = int'(ptr) + i;
      if (c >= N) c = c - N;
      if (!found && req[c[IW-1:0]]) begin
        found = 1'b1;
        idx   = c[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/stream_rr_arb.sv
// N-way round-robin stream arbiter feeding a single registered output stage.
// Define STREAM_RR_ARB_PKT_LOCK_EN to hold the grant on one requester until its i_last beat.
module stream_rr_arb
  import stream_arb_pkg::*;
#(
  parameter  int WIDTH = DEF_WIDTH,
  parameter  int N     = DEF_N,
  localparam int IW    = $clog2(N)
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  input  logic [N*WIDTH-1:0] i_data,
  input  logic [N-1:0]       i_vld,
  input  logic [N-1:0]       i_last,
  output logic [N-1:0]       o_rdy,
  output logic [WIDTH-1:0]   o_data,
  output logic               o_vld,
  output logic               o_last,
  output logic [IW-1:0]      o_grant,
  input  logic               i_rdy
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             vld_q, vld_d;
  logic             last_q, last_d;
  logic [IW-1:0]    grant_q, grant_d;
  logic [IW-1:0]    ptr_q, ptr_d;

  logic             ld;
  logic             acc;
  logic             any_vld;
  logic [IW-1:0]    rr_idx;
  logic [IW-1:0]    win_idx;
  logic [N-1:0]     rdy;

  rr_pick #(
    .N  (N),
    .IW (IW)
  ) u_rr_pick (
    .req (i_vld),
    .ptr (ptr_q),
    .any (any_vld),
    .idx (rr_idx)
  );

`ifdef STREAM_RR_ARB_PKT_LOCK_EN
  lock_state_e   state_q, state_d;
  logic [IW-1:0] lock_idx_q, lock_idx_d;
  logic          locked;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q    <= IDLE;
      lock_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      lock_idx_q <= lock_idx_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    lock_idx_d = lock_idx_q;
    case (state_q)
      IDLE: begin
        if (acc && !i_last[win_idx]) begin
          state_d    = LOCKED;
          lock_idx_d = win_idx;
        end
      end
      LOCKED: begin
        if (acc && i_last[win_idx]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    locked = (state_q == LOCKED);
  end

  // While locked, only the owning requester can be offered o_rdy.
  assign win_idx = locked ? lock_idx_q : rr_idx;
`else
  assign win_idx = rr_idx;
`endif

  always_comb begin
    ld      = !vld_q || i_rdy;
    acc     = i_reset_n && ld && any_vld && i_vld[win_idx];
    rdy     = '0;
    if (i_reset_n && ld && any_vld) rdy[win_idx] = 1'b1;

    data_d  = data_q;
    vld_d   = vld_q;
    last_d  = last_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    if (acc) begin
      data_d  = i_data[win_idx*WIDTH +: WIDTH];
      vld_d   = 1'b1;
      last_d  = i_last[win_idx];
      grant_d = win_idx;
      ptr_d   = win_idx;
    end else if (ld) begin
      vld_d   = 1'b0;
    end
  end

  // Reset leaves ptr at N-1 so the first search starts from requester 0.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      data_q  <= '0;
      vld_q   <= 1'b0;
      last_q  <= 1'b0;
      grant_q <= '0;
      ptr_q   <= IW'(N - 1);
    end else begin
      data_q  <= data_d;
      vld_q   <= vld_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
    end
  end

  assign o_rdy   = rdy;
  assign o_data  = data_q;
  assign o_vld   = vld_q;
  assign o_last  = last_q;
  assign o_grant = grant_q;

endmodule

// File: tb/tb_stream_rr_arb.sv
// Scoreboard bench for stream_rr_arb (N=4, WIDTH=8); expected beats are queued by the
// driver and checked by a monitor whenever the output stage holds a valid beat.
module tb_stream_rr_arb;

  localparam int WIDTH = 8;
  localparam int N     = 4;

  typedef struct {
    logic [1:0] g;
    logic [7:0] d;
    logic       l;
  } beat_t;

  logic             i_clk = 1'b0;
  logic             i_reset_n;
  logic [N*WIDTH-1:0] i_data;
  logic [N-1:0]     i_vld;
  logic [N-1:0]     i_last;
  logic [N-1:0]     o_rdy;
  logic [WIDTH-1:0] o_data;
  logic             o_vld;
  logic             o_last;
  logic [1:0]       o_grant;
  logic             i_rdy;

  beat_t exp_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  stream_rr_arb #(.WIDTH(WIDTH), .N(N)) dut (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_data    (i_data),
    .i_vld     (i_vld),
    .i_last    (i_last),
    .o_rdy     (o_rdy),
    .o_data    (o_data),
    .o_vld     (o_vld),
    .o_last    (o_last),
    .o_grant   (o_grant),
    .i_rdy     (i_rdy)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: a valid beat must match the queue head; it is popped when it drains.
  always @(negedge i_clk) begin
    if (i_reset_n && o_vld) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_beat: got grant %0d data 0x%0h, expected no beat", o_grant, o_data);
      end else begin
        chk("o_grant", 32'(o_grant), 32'(exp_q[0].g));
        chk("o_data", 32'(o_data), 32'(exp_q[0].d));
        chk("o_last", 32'(o_last), 32'(exp_q[0].l));
        if (i_rdy) void'(exp_q.pop_front());
      end
    end
  end

  // One cycle of stimulus; called at posedge+1. exp_rdy is the hand-computed o_rdy.
  task automatic step(input logic [3:0] vld, input logic [3:0] last, input logic rdy,
                      input logic [3:0] exp_rdy);
    beat_t b;
    logic  accepted;
    i_vld  = vld;
    i_last = last;
    i_rdy  = rdy;
    #1;
    chk("o_rdy", 32'(o_rdy), 32'(exp_rdy));
    accepted = (exp_rdy & vld) != 4'b0;
    if (accepted) begin
      b.g = 2'd0;
      for (int k = 0; k < N; k++) if (exp_rdy[k]) b.g = 2'(k);
      b.d = i_data[b.g*WIDTH +: WIDTH];
      b.l = last[b.g];
      exp_q.push_back(b);
    end
    @(posedge i_clk);
    #1;
    if (accepted)  chk("latency_o_vld", 32'(o_vld), 32'd1);
    else if (rdy)  chk("idle_o_vld", 32'(o_vld), 32'd0);
  endtask

  task automatic reset_cycle();
    i_reset_n = 1'b0;
    i_vld     = 4'hF;
    i_last    = 4'hF;
    i_rdy     = 1'b0;
    #1;
    chk("rst_o_rdy", 32'(o_rdy), 32'd0);
    @(posedge i_clk);
    #1;
    chk("rst_o_vld", 32'(o_vld), 32'd0);
    chk("rst_o_data", 32'(o_data), 32'd0);
    chk("rst_o_last", 32'(o_last), 32'd0);
    chk("rst_o_grant", 32'(o_grant), 32'd0);
    exp_q.delete();
    i_reset_n = 1'b1;
    i_vld     = 4'h0;
    i_last    = 4'h0;
  endtask

  initial begin
    i_reset_n = 1'b0;
    i_data    = {8'h44, 8'h33, 8'h22, 8'h11};
    i_vld     = '0;
    i_last    = '0;
    i_rdy     = 1'b0;
    @(posedge i_clk);
    #1;
    reset_cycle();

    // All requesters valid: grant rotates 0,1,2,3 and wraps.
    for (int c = 0; c < 8; c++) step(4'hF, 4'hF, 1'b1, 4'(1 << (c % 4)));
    step(4'h0, 4'h0, 1'b1, 4'h0);

    // Single active requester wins every cycle, no bubbles.
    i_data = {8'h44, 8'hA5, 8'h22, 8'h11};
    for (int c = 0; c < 4; c++) step(4'b0100, 4'hF, 1'b1, 4'b0100);
    step(4'h0, 4'h0, 1'b1, 4'h0);

    // Backpressure holds 0x11, then drain and load on the same edge.
    i_data = {8'h44, 8'h33, 8'h22, 8'h11};
    step(4'b0001, 4'hF, 1'b1, 4'b0001);
    for (int c = 0; c < 3; c++) begin
      step(4'b0011, 4'hF, 1'b0, 4'b0000);
      chk("stall_o_data", 32'(o_data), 32'h11);
    end
    step(4'b0011, 4'hF, 1'b1, 4'b0010);
    step(4'h0, 4'h0, 1'b1, 4'h0);

    // Requester 1 sends a 3-beat packet while requester 0 is also valid.
    step(4'b0001, 4'hF, 1'b1, 4'b0001);
`ifdef STREAM_RR_ARB_PKT_LOCK_EN
    step(4'b0011, 4'b0001, 1'b1, 4'b0010);
    step(4'b0011, 4'b0001, 1'b1, 4'b0010);
    step(4'b0011, 4'b0011, 1'b1, 4'b0010);
    step(4'b0011, 4'b0001, 1'b1, 4'b0001);
`else
    step(4'b0011, 4'b0001, 1'b1, 4'b0010);
    step(4'b0011, 4'b0001, 1'b1, 4'b0001);
    step(4'b0011, 4'b0011, 1'b1, 4'b0010);
    step(4'b0011, 4'b0001, 1'b1, 4'b0001);
`endif
    step(4'h0, 4'h0, 1'b1, 4'h0);

    // Start a packet on requester 1, stall, then reset mid-packet.
    step(4'b0010, 4'b0000, 1'b1, 4'b0010);
    step(4'b0010, 4'b0000, 1'b0, 4'b0000);
    reset_cycle();
    step(4'b1001, 4'hF, 1'b1, 4'b0001);
    step(4'b1001, 4'hF, 1'b1, 4'b1000);
    step(4'h0, 4'h0, 1'b1, 4'h0);
    step(4'h0, 4'h0, 1'b1, 4'h0);

    chk("leftover_beats", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/stream_rr_arb.md
STREAM_RR_ARB -- requirements
Module: stream_rr_arb

Interface
REQ-001 Parameter WIDTH, default 8, payload width in bits per requester.
REQ-002 Parameter N, default 4, number of requesters, legal range 2..16; IW = clog2(N).
REQ-003 i_clk  input  1  sole clock; all state updates on rising edge.
REQ-004 i_reset_n  input  1  reset, synchronous and active-low.
REQ-005 i_data  input  N*WIDTH  requester payloads; requester k occupies bits [k*WIDTH +: WIDTH].
REQ-006 i_vld  input  N  per-requester valid.
REQ-007 i_last  input  N  per-requester end-of-packet flag, qualified by i_vld[k].
REQ-008 o_rdy  output  N  per-requester ready; at most one bit set in any cycle.
REQ-009 o_data  output  WIDTH  registered payload toward the shared pipe_stage.
REQ-010 o_vld  output  1  registered valid toward the shared pipe_stage.
REQ-011 o_last  output  1  registered end-of-packet flag accompanying o_data.
REQ-012 o_grant  output  IW  registered index of the requester whose beat is in o_data.
REQ-013 i_rdy  input  1  downstream ready.

Function
REQ-014 Load enable ld = !o_vld || i_rdy; a beat is accepted from requester k when ld && o_rdy[k] && i_vld[k].
REQ-015 o_rdy[k] = ld && (winner == k) && (any i_vld set); o_rdy is combinational from i_rdy, i_vld and state.
REQ-016 Winner = first requester with i_vld set, searching ptr+1, ptr+2, ... modulo N (round-robin).
REQ-017 On accept: o_data, o_last, o_grant load the winner's payload, i_last and index; o_vld is set to 1; ptr is set to the winner index.
REQ-018 When ld && no i_vld: o_vld is set to 0; o_data, o_last, o_grant hold.
REQ-019 When !ld (o_vld && !i_rdy): all outputs hold and o_rdy is all zero (backpressure).
REQ-020 Latency: an accepted beat appears on o_vld/o_data the next cycle; back-to-back beats sustain 1 beat/cycle while i_rdy is high.
REQ-021 o_data/o_last/o_grant are never changed while o_vld && !i_rdy.
REQ-022 ptr wraps from N-1 to 0; a single active requester wins every cycle (no idle gap).
REQ-023 Simultaneous i_rdy and new accept in one cycle: the old beat drains and the new beat loads in the same edge.

Reset
REQ-024 While i_reset_n is low at a rising edge: o_vld=0, o_data=0, o_last=0, o_grant=0, ptr=N-1, lock state IDLE.
REQ-025 Reset mid-packet or mid-backpressure discards the held beat; the first post-reset winner is the lowest-index valid requester.
REQ-026 o_rdy is all zero during any cycle in which i_reset_n is low.

Configuration
REQ-027 Macro STREAM_RR_ARB_PKT_LOCK_EN selects packet lock.
REQ-028 Defined: a two-state FSM with states IDLE and LOCKED; an accept with i_last=0 moves IDLE->LOCKED with the lock held on the winner; in LOCKED the winner is forced to the locked index (other requesters see o_rdy=0 even if locked i_vld=0); an accept from the locked index with i_last=1 moves LOCKED->IDLE.
REQ-029 Undefined: no FSM; arbitration is per beat per REQ-016; i_last is passed through to o_last only.

Structure
REQ-030 Package stream_arb_pkg holds the lock FSM state typedef (IDLE, LOCKED) and the default WIDTH/N constants.
REQ-031 The round-robin priority search is a combinational sub-module rr_pick (inputs: request vector, ptr; outputs: any, winner index).

Verification
REQ-032 N=4, all i_vld=1, i_last=1, i_rdy=1 for 8 cycles after reset -> o_grant sequence 0,1,2,3,0,1,2,3.
REQ-033 Only requester 2 valid, data 0xA5, i_rdy=1 -> o_rdy=4'b0100 every cycle, o_data=0xA5 with o_grant=2 one cycle later, no bubbles.
REQ-034 o_vld=1 with o_data=0x11, i_rdy=0 for 3 cycles -> o_data stays 0x11, o_rdy=0; i_rdy=1 -> next beat loads the same edge the old one drains.
REQ-035 With LOCK_EN: requester 1 sends 3 beats (last on 3rd) while requester 0 is valid -> o_grant 1,1,1 then 0; without LOCK_EN -> o_grant alternates 1,0,1,0.
REQ-036 i_reset_n low for one cycle while o_vld=1 and LOCKED -> next cycle o_vld=0, o_grant=0, state IDLE; requesters 0 and 3 valid -> requester 0 wins first.
